gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_pkg.sv | 10 +
 rtl/binary_gray.sv | 13 +
 rtl/gray_counter.sv | 59 +++++
 tb/tb_gray_counter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared constants for the Gray-code counter
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  // Wide all-ones pattern; users slice it to their own WIDTH for the terminal value.
  localparam logic [MAX_WIDTH-1:0] ALL_ONES = {MAX_WIDTH{1'b1}};

endpackage

// File: rtl/binary_gray.sv
// rtl/binary_gray.sv - combinational binary-to-Gray converter (inverse of gray_binary)
module binary_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - loadable up/down counter with registered binary, Gray and wrap outputs
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TERM = ALL_ONES[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             tc_next;

  always_comb begin
    bin_next = binary;
    tc_next  = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (up_dn) begin
        bin_next = binary + ONE;
        tc_next  = (binary == TERM);
      end else begin
        bin_next = binary - ONE;
        tc_next  = (binary == '0);
      end
    end
  end

  // Gray is encoded from the next binary value so both registers move together.
  binary_gray #(.WIDTH(WIDTH)) u_binary_gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      binary <= '0;
      gray   <= '0;
      tc     <= 1'b0;
    end else begin
      binary <= bin_next;
      gray   <= gray_next;
      tc     <= tc_next;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - directed table-driven bench for gray_counter
module tb_gray_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] binary;
  logic [W-1:0] gray;
  logic         tc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic         rst;
    logic         load;
    logic         en;
    logic         up_dn;
    logic [W-1:0] load_bin;
    logic [W-1:0] exp_bin;
    logic [W-1:0] exp_gray;
    logic         exp_tc;
  } vec_t;

  vec_t vecs[$];

  gray_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .binary   (binary),
    .gray     (gray),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic add(input string name, input logic r, input logic ld, input logic e,
                     input logic ud, input logic [W-1:0] lb, input logic [W-1:0] eb,
                     input logic [W-1:0] eg, input logic et);
    vec_t v;
    v.name = name; v.rst = r; v.load = ld; v.en = e; v.up_dn = ud; v.load_bin = lb;
    v.exp_bin = eb; v.exp_gray = eg; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic ld, input logic e, input logic ud,
                      input logic [W-1:0] lb);
    rst = r; load = ld; en = e; up_dn = ud; load_bin = lb;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] eb, input logic [W-1:0] eg,
                       input logic et);
    checks++;
    if (binary !== eb || gray !== eg || tc !== et) begin
      failures++;
      $display("FAIL %s: got bin=%b gray=%b tc=%b, want bin=%b gray=%b tc=%b",
               name, binary, gray, tc, eb, eg, et);
    end
  endtask

  initial begin
    logic [W-1:0] sweep_gray [16];
    logic [W-1:0] model;
    logic [W-1:0] prev_gray;
    int           tc_count;

    sweep_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                   4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    // Reset dominates a simultaneous load
    add("reset0", 1, 1, 1, 1, 4'b1010, 4'b0000, 4'b0000, 0);
    add("reset1", 1, 1, 1, 1, 4'b1010, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 16; i++)
      add($sformatf("up_sweep%0d", i), 0, 0, 1, 1, 4'b0000, 4'((i + 1) % 16), sweep_gray[i],
          (i == 15) ? 1'b1 : 1'b0);
    add("down_wrap",   0, 0, 1, 0, 4'b0000, 4'b1111, 4'b1000, 1);
    add("down_next",   0, 0, 1, 0, 4'b0000, 4'b1110, 4'b1001, 0);
    add("load_prio",   0, 1, 1, 1, 4'b1010, 4'b1010, 4'b1111, 0);
    add("after_load",  0, 0, 1, 1, 4'b0000, 4'b1011, 4'b1110, 0);
    add("load_ones",   0, 1, 0, 0, 4'b1111, 4'b1111, 4'b1000, 0);
    add("ones_up",     0, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 1);
    add("load_zero",   0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add("mid_up1",     0, 0, 1, 1, 4'b0000, 4'b0001, 4'b0001, 0);
    add("mid_up2",     0, 0, 1, 1, 4'b0000, 4'b0010, 4'b0011, 0);
    add("mid_up3",     0, 0, 1, 1, 4'b0000, 4'b0011, 4'b0010, 0);
    add("mid_up4",     0, 0, 1, 1, 4'b0000, 4'b0100, 4'b0110, 0);
    add("mid_up5",     0, 0, 1, 1, 4'b0000, 4'b0101, 4'b0111, 0);
    add("mid_up6",     0, 0, 1, 1, 4'b0000, 4'b0110, 4'b0101, 0);
    add("mid_rst",     1, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    add("resume",      0, 0, 1, 1, 4'b0000, 4'b0001, 4'b0001, 0);
    add("load5",       0, 1, 0, 1, 4'b0101, 4'b0101, 4'b0111, 0);
    add("dir_change",  0, 0, 1, 0, 4'b0000, 4'b0100, 4'b0110, 0);
    add("idle_hold0",  0, 0, 0, 1, 4'b1111, 4'b0100, 4'b0110, 0);
    add("idle_hold1",  0, 0, 0, 0, 4'b0011, 4'b0100, 4'b0110, 0);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].load, vecs[k].en, vecs[k].up_dn, vecs[k].load_bin);
      check(vecs[k].name, vecs[k].exp_bin, vecs[k].exp_gray, vecs[k].exp_tc);
    end

    // Continuous counting over three wraps each way: single-bit Gray steps, periodic tc.
    for (int dir = 1; dir >= 0; dir--) begin
      step(1, 0, 0, 0, '0);
      check("run_reset", 4'b0000, 4'b0000, 0);
      model     = '0;
      prev_gray = '0;
      tc_count  = 0;
      for (int c = 0; c < 48; c++) begin
        logic wrap;
        wrap  = (dir == 1) ? (model == 4'b1111) : (model == 4'b0000);
        model = (dir == 1) ? model + 4'd1 : model - 4'd1;
        step(0, 0, 1, dir[0], '0);
        check($sformatf("run%0d_c%0d", dir, c), model, model ^ (model >> 1), wrap);
        checks++;
        if ($countones(gray ^ prev_gray) != 1) begin
          failures++;
          $display("FAIL onebit%0d_c%0d: got gray %b after %b, want exactly one bit change",
                   dir, c, gray, prev_gray);
        end
        prev_gray = gray;
        if (tc === 1'b1) tc_count++;
      end
      checks++;
      if (tc_count != 3) begin
        failures++;
        $display("FAIL tc_period%0d: got %0d pulses, want 3", dir, tc_count);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
